// File: rtl/adc_scan_ctrl.sv
// SPI scan controller for the ADC128S022: sequences channels 0..NUM_CH-1,
// keeps the latest reading per channel and a per-channel line-detect bit.
module adc_scan_ctrl #(
  parameter int NUM_CH  = 3,
  parameter int CLK_DIV = 8
) (
  input  logic                   clock_in,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   continuous,
  input  logic [11:0]            threshold,
  input  logic                   miso,
  output logic                   adc_cs_n,
  output logic                   adc_sclk,
  output logic                   mosi,
  output logic                   busy,
  output logic                   sample_valid,
  output logic [2:0]             sample_ch,
  output logic [11:0]            sample_data,
  output logic [12*NUM_CH-1:0]   readings,
  output logic [NUM_CH-1:0]      line_detect,
  output logic                   scan_done,
  output logic [1:0]             fsm_state
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD} state_t;

  state_t         state, state_nxt;
  logic [DW-1:0]  div_cnt;
  logic [4:0]     half_idx;
  logic [2:0]     ch;
  logic [11:0]    shreg;

  logic           div_last, last_ch, frame_end, scan_end;
  logic [2:0]     next_ch;
  logic [4:0]     half_nxt;
  logic [3:0]     bit_nxt;
  logic           addr_bit;

  assign fsm_state = state;

  always_comb begin
    div_last  = (div_cnt == DW'(CLK_DIV - 1));
    last_ch   = (ch == 3'(NUM_CH - 1));
    frame_end = (state == SHIFT) && div_last && (half_idx == 5'd31);
    scan_end  = frame_end && last_ch;
    next_ch   = last_ch ? 3'd0 : ch + 3'd1;
    half_nxt  = half_idx + 5'd1;
    bit_nxt   = half_nxt[4:1];
    addr_bit  = 1'b0;
    case (bit_nxt)
      4'd2:    addr_bit = next_ch[2];
      4'd3:    addr_bit = next_ch[1];
      4'd4:    addr_bit = next_ch[0];
      default: addr_bit = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start || continuous) state_nxt = CS_SETUP;
      CS_SETUP: if (div_last)            state_nxt = SHIFT;
      SHIFT:    if (scan_end && !continuous) state_nxt = CS_HOLD;
      CS_HOLD:  if (div_last)            state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      div_cnt      <= '0;
      half_idx     <= '0;
      ch           <= '0;
      shreg        <= '0;
      adc_cs_n     <= 1'b1;
      adc_sclk     <= 1'b1;
      mosi         <= 1'b0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      scan_done    <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
      readings     <= '0;
      line_detect  <= '0;
    end else begin
      sample_valid <= 1'b0;
      scan_done    <= 1'b0;
      if (state == IDLE)  div_cnt <= '0;
      else if (div_last)  div_cnt <= '0;
      else                div_cnt <= div_cnt + DW'(1);

      case (state)
        IDLE: if (start || continuous) begin
          busy     <= 1'b1;
          adc_cs_n <= 1'b0;
          ch       <= '0;
        end
        CS_SETUP: if (div_last) begin
          adc_sclk <= 1'b0;
          mosi     <= 1'b0;
          half_idx <= '0;
        end
        SHIFT: if (div_last) begin
          if (half_idx == 5'd31) begin
            sample_valid <= 1'b1;
            sample_data  <= shreg;
            sample_ch    <= ch;
            scan_done    <= last_ch;
            for (int n = 0; n < NUM_CH; n++) begin
              if (ch == 3'(n)) begin
                readings[n*12 +: 12] <= shreg;
                line_detect[n]       <= (shreg > threshold);
              end
            end
            ch <= next_ch;
            if (scan_end && !continuous) begin
              adc_cs_n <= 1'b1;
            end else begin
              adc_sclk <= 1'b0;
              mosi     <= 1'b0;
              half_idx <= '0;
            end
          end else begin
            half_idx <= half_nxt;
            if (!half_nxt[0]) begin
              adc_sclk <= 1'b0;
              mosi     <= addr_bit;
            end else begin
              adc_sclk <= 1'b1;
              // All 16 bits shift through; only the last 12 (bits 4..15) survive.
              shreg    <= {shreg[10:0], miso};
            end
          end
        end
        CS_HOLD: if (div_last) busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Bench for adc_scan_ctrl: behavioural ADC128S022 model, expected-queue
// scoreboard and directed/random scans on a 3-channel and a 1-channel build.
module tb_adc_scan_ctrl;
  localparam int N = 3, D = 8, D1 = 2;
  localparam int EXP_W = 3 + 12 + 1 + 36 + 3;

  typedef struct packed {
    logic [2:0]  ch;
    logic [11:0] data;
    logic        done;
    logic [35:0] rd;
    logic [2:0]  ld;
  } exp_t;

  // clock / reset
  logic clock_in = 1'b0;
  logic reset = 1'b1;
  always #5 clock_in = ~clock_in;
  int cyc = 0;
  always @(posedge clock_in) cyc++;

  logic start = 1'b0, continuous = 1'b0, miso = 1'b0;
  logic [11:0] threshold = 12'hFFF;
  logic adc_cs_n, adc_sclk, mosi, busy, sample_valid, scan_done;
  logic [2:0] sample_ch;
  logic [11:0] sample_data;
  logic [12*N-1:0] readings;
  logic [N-1:0] line_detect;
  logic [1:0] fsm_state;

  logic start1 = 1'b0, cont1 = 1'b0, miso1 = 1'b0;
  logic adc_cs_n1, adc_sclk1, mosi1, busy1, sample_valid1, scan_done1;
  logic [2:0] sample_ch1;
  logic [11:0] sample_data1;
  logic [11:0] readings1;
  logic [0:0] line_detect1;
  logic [1:0] fsm_state1;

  adc_scan_ctrl #(.NUM_CH(N), .CLK_DIV(D)) dut (
    .clock_in(clock_in), .reset(reset), .start(start), .continuous(continuous),
    .threshold(threshold), .miso(miso), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk),
    .mosi(mosi), .busy(busy), .sample_valid(sample_valid), .sample_ch(sample_ch),
    .sample_data(sample_data), .readings(readings), .line_detect(line_detect),
    .scan_done(scan_done), .fsm_state(fsm_state));

  adc_scan_ctrl #(.NUM_CH(1), .CLK_DIV(D1)) dut1 (
    .clock_in(clock_in), .reset(reset), .start(start1), .continuous(cont1),
    .threshold(threshold), .miso(miso1), .adc_cs_n(adc_cs_n1), .adc_sclk(adc_sclk1),
    .mosi(mosi1), .busy(busy1), .sample_valid(sample_valid1), .sample_ch(sample_ch1),
    .sample_data(sample_data1), .readings(readings1), .line_detect(line_detect1),
    .scan_done(scan_done1), .fsm_state(fsm_state1));

  int chk_cnt = 0, pass_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ADC models: conversion data of the addressed channel, MSB-first after 4 zeros
  logic [11:0] adc_val [8];
  logic [11:0] adc1_val [8];
  logic [3:0] a_bit = 0, a1_bit = 0;
  logic [2:0] a_ch = 0, a_addr = 0, a1_ch = 0, a1_addr = 0;
  int a_frame = 0, a1_frame = 0;

  always @(posedge adc_cs_n) begin a_bit = 0; a_ch = 0; a_frame = 0; end
  always @(negedge adc_sclk) if (adc_cs_n === 1'b0) begin
    miso = (a_bit < 4) ? 1'b0 : adc_val[a_ch][15 - int'(a_bit)];
    a_bit = a_bit + 4'd1;
  end
  always @(posedge adc_sclk) if (adc_cs_n === 1'b0) begin
    logic [3:0] b;
    b = a_bit - 4'd1;
    if (b >= 2 && b <= 4) a_addr[4 - int'(b)] = mosi;
    if (b == 15) begin
      chk("frame_addr", a_addr, 3'((a_frame + 1) % N));
      a_ch = a_addr;
      a_frame++;
    end
  end

  always @(posedge adc_cs_n1) begin a1_bit = 0; a1_ch = 0; a1_frame = 0; end
  always @(negedge adc_sclk1) if (adc_cs_n1 === 1'b0) begin
    miso1 = (a1_bit < 4) ? 1'b0 : adc1_val[a1_ch][15 - int'(a1_bit)];
    a1_bit = a1_bit + 4'd1;
  end
  always @(posedge adc_sclk1) if (adc_cs_n1 === 1'b0) begin
    logic [3:0] b;
    b = a1_bit - 4'd1;
    if (b >= 2 && b <= 4) a1_addr[4 - int'(b)] = mosi1;
    if (b == 15) begin
      chk("frame_addr_1ch", a1_addr, 3'd0);
      a1_ch = a1_addr;
      a1_frame++;
    end
  end

  // reference model: latest reading and detect bit per channel
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] exp1_q[$];
  logic [11:0] m_rd [N];
  logic [N-1:0] m_ld = '0;
  logic [11:0] m1_rd = '0;
  logic m1_ld = 1'b0;

  task automatic push_frames(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      int c = k % N;
      m_rd[c] = adc_val[c];
      m_ld[c] = adc_val[c] > threshold;
      e.ch = 3'(c); e.data = adc_val[c]; e.done = (c == N - 1);
      e.rd = {m_rd[2], m_rd[1], m_rd[0]}; e.ld = m_ld;
      exp_q.push_back(e);
    end
  endtask

  task automatic push1_frames(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      m1_rd = adc1_val[0];
      m1_ld = adc1_val[0] > threshold;
      e.ch = 3'd0; e.data = adc1_val[0]; e.done = 1'b1;
      e.rd = {24'd0, m1_rd}; e.ld = {2'b00, m1_ld};
      exp1_q.push_back(e);
    end
  endtask

  // monitors
  exp_t me0, me1;
  always @(negedge clock_in) if (!reset) begin
    if (sample_valid) begin
      if (exp_q.size() == 0) chk("strobe_unexpected", sample_valid, 1'b0);
      else begin
        me0 = exp_q.pop_front();
        chk("sample_ch", sample_ch, me0.ch);
        chk("sample_data", sample_data, me0.data);
        chk("scan_done", scan_done, me0.done);
        chk("readings", readings, me0.rd);
        chk("line_detect", line_detect, me0.ld);
      end
    end else if (scan_done) chk("scan_done_alone", sample_valid, 1'b1);
    if (sample_valid1) begin
      if (exp1_q.size() == 0) chk("strobe_unexpected_1ch", sample_valid1, 1'b0);
      else begin
        me1 = exp1_q.pop_front();
        chk("sample_ch_1ch", sample_ch1, me1.ch);
        chk("sample_data_1ch", sample_data1, me1.data);
        chk("scan_done_1ch", scan_done1, me1.done);
        chk("readings_1ch", readings1, me1.rd);
        chk("line_detect_1ch", line_detect1, me1.ld);
      end
    end
  end

  // driver tasks
  task automatic pulse_start();
    @(posedge clock_in); #1 start = 1'b1;
    @(posedge clock_in); #1 start = 1'b0;
  endtask

  task automatic pulse_start1();
    @(posedge clock_in); #1 start1 = 1'b1;
    @(posedge clock_in); #1 start1 = 1'b0;
  endtask

  task automatic wait_for(input int sel, input logic lvl, input int budget, input string name);
    int n = 0;
    logic v;
    do begin
      @(negedge clock_in);
      n++;
      case (sel)
        0: v = adc_cs_n;
        1: v = busy;
        2: v = sample_valid;
        3: v = adc_cs_n1;
        4: v = busy1;
        default: v = sample_valid1;
      endcase
    end while (v !== lvl && n < budget);
    if (v !== lvl) chk(name, v, lvl);
  endtask

  task automatic check_rst();
    chk("rst_cs_n", adc_cs_n, 1'b1);
    chk("rst_sclk", adc_sclk, 1'b1);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", sample_valid, 1'b0);
    chk("rst_done", scan_done, 1'b0);
    chk("rst_ch", sample_ch, 3'd0);
    chk("rst_data", sample_data, 12'd0);
    chk("rst_readings", readings, 36'd0);
    chk("rst_ld", line_detect, 3'd0);
  endtask

  task automatic rand_vals();
    for (int c = 0; c < 8; c++) begin
      adc_val[c]  = 12'((c << 9) | $urandom_range(0, 511));
      adc1_val[c] = 12'((c << 9) | $urandom_range(0, 511));
    end
    if ($urandom_range(0, 1) == 1) threshold = adc_val[$urandom_range(0, N - 1)];
    else threshold = 12'($urandom_range(0, 4095));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, ns, hi, n;
    for (int c = 0; c < N; c++) m_rd[c] = '0;
    repeat (3) @(posedge clock_in);
    #1 reset = 1'b0;
    @(negedge clock_in);
    check_rst();

    // fixed pattern: timing, addresses, data
    for (int c = 0; c < 8; c++) begin
      adc_val[c]  = 12'h0A5 + 12'(c * 256);
      adc1_val[c] = 12'h0A5 + 12'(c * 256);
    end
    threshold = 12'h0FF;
    push_frames(3);
    pulse_start();
    wait_for(0, 1'b0, 10, "cs_fall");
    t0 = cyc;
    wait_for(2, 1'b1, 300, "strobe0");
    chk("first_latency", cyc - t0, 264);
    t1 = cyc;
    wait_for(2, 1'b1, 300, "strobe1");
    chk("gap1", cyc - t1, 256);
    t1 = cyc;
    wait_for(2, 1'b1, 300, "strobe2");
    chk("gap2", cyc - t1, 256);
    chk("cs_rise_last", adc_cs_n, 1'b1);
    t0 = cyc;
    wait_for(1, 1'b0, 20, "busy_fall");
    chk("cs_hold_len", cyc - t0, 8);

    // equal value is not detected
    threshold = 12'h1A5;
    push_frames(3);
    pulse_start();
    wait_for(1, 1'b0, 1000, "idle3");
    chk("ld_equal", line_detect, 3'b100);

    // continuous, dropped during frame 4
    rand_vals();
    push_frames(6);
    @(posedge clock_in); #1 continuous = 1'b1;
    wait_for(0, 1'b0, 10, "cs_fall4");
    ns = 0; hi = 0; n = 0;
    while (ns < 6 && n < 3000) begin
      @(negedge clock_in);
      n++;
      if (sample_valid) begin
        ns++;
        if (ns == 3) continuous = 1'b0;
      end
      if (adc_cs_n && ns < 6) hi++;
    end
    chk("cont_strobes", ns, 6);
    chk("cont_cs_low", hi, 0);
    wait_for(1, 1'b0, 20, "idle4");
    repeat (30) @(negedge clock_in);
    chk("idle4_cs", adc_cs_n, 1'b1);

    // reset at bit 9 of frame 1
    rand_vals();
    push_frames(1);
    pulse_start();
    wait_for(0, 1'b0, 10, "cs_fall5");
    repeat (8 + 256 + 9 * 16 + 3) @(negedge clock_in);
    reset = 1'b1;
    @(negedge clock_in);
    chk("rst_cs_next", adc_cs_n, 1'b1);
    repeat (2) @(negedge clock_in);
    reset = 1'b0;
    @(negedge clock_in);
    check_rst();
    for (int c = 0; c < N; c++) m_rd[c] = '0;
    m_ld = '0; m1_rd = '0; m1_ld = 1'b0;
    push_frames(3);
    pulse_start();
    wait_for(1, 1'b0, 1000, "idle5");

    // start while busy and during CS hold
    rand_vals();
    push_frames(3);
    pulse_start();
    repeat (100) @(negedge clock_in);
    pulse_start();
    wait_for(0, 1'b1, 1000, "cs_rise6");
    t0 = cyc;
    pulse_start();
    wait_for(1, 1'b0, 20, "busy_fall6");
    chk("hold6_len", cyc - t0, 8);
    hi = 0;
    repeat (40) begin
      @(negedge clock_in);
      if (!adc_cs_n || busy) hi++;
    end
    chk("start_ignored", hi, 0);

    // random single scans
    for (int i = 0; i < 4; i++) begin
      rand_vals();
      push_frames(3);
      pulse_start();
      wait_for(1, 1'b0, 1000, "idle_rand");
      repeat ($urandom_range(1, 20)) @(negedge clock_in);
    end

    // single-channel build
    rand_vals();
    push1_frames(1);
    pulse_start1();
    wait_for(3, 1'b0, 10, "cs_fall_1ch");
    t0 = cyc;
    wait_for(5, 1'b1, 100, "strobe_1ch");
    chk("first_latency_1ch", cyc - t0, 2 + 64);
    wait_for(4, 1'b0, 20, "idle_1ch");
    push1_frames(3);
    @(posedge clock_in); #1 cont1 = 1'b1;
    ns = 0; n = 0;
    while ((ns == 0 || busy1) && n < 600) begin
      @(negedge clock_in);
      n++;
      if (sample_valid1) begin
        ns++;
        if (ns == 2) cont1 = 1'b0;
      end
    end
    chk("cont_strobes_1ch", ns, 3);
    chk("idle_after_1ch", busy1, 1'b0);

    repeat (10) @(negedge clock_in);
    chk("queue_empty", exp_q.size(), 0);
    chk("queue_empty_1ch", exp1_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
